// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one NIBBLE-bit slice per clock, LSB slice first.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.

module nibble_sub_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);
  logic [N:0] sum;
  // Two's-complement subtract: a + ~b + ~borrow; borrow-out is the inverted carry.
  assign sum  = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, ~bin};
  assign d    = sum[N-1:0];
  assign bout = ~sum[N];
endmodule

module nibble_serial_subtractor #(
  parameter int WIDTH  = 16,
  parameter int NIBBLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             bout
);
  localparam int STEPS = WIDTH / NIBBLE;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [SW-1:0]    step_q, step_d;
  logic             borrow_q, borrow_d, bout_q, bout_d, ovf_q, ovf_d;

  logic [IW-1:0]     base;
  logic [NIBBLE-1:0] sl_a, sl_b, sl_d;
  logic              sl_bout;
  logic              last;

  assign base = IW'(step_q) * IW'(NIBBLE);
  assign sl_a = NIBBLE'(a_q >> base);
  assign sl_b = NIBBLE'(b_q >> base);
  assign last = (step_q == SW'(STEPS - 1));

  nibble_sub_slice #(.N(NIBBLE)) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .bin (borrow_q),
    .d   (sl_d),
    .bout(sl_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    step_d   = step_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d      = a;
        b_d      = b;
        borrow_d = bin;
        step_d   = '0;
        state_d  = BUSY;
      end
      BUSY: begin
        diff_d[base +: NIBBLE] = sl_d;
        borrow_d = sl_bout;
        step_d   = step_q + SW'(1);
        if (last) begin
          step_d  = '0;
          bout_d  = sl_bout;
          // Overflow uses the final slice's MSB, so bin is already folded in.
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sl_d[NIBBLE-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      step_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      step_q   <= step_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule
